// File: rtl/if_id_ex_mem_pipeline_regs_if.sv
// Bundle of all IF/ID, ID/EX and EX/MEM pipeline-register inputs and outputs.
// The master side drives the stage inputs and observes the registered outputs.
interface if_id_ex_mem_pipeline_regs_if;
   logic        ifid_enable;
   logic [31:0] ifid_alu_data, ifid_inst_mem_data;
   logic [31:0] ifid_alu_data_out, ifid_inst_mem_data_out;

   logic        idex_stall;
   logic [31:0] idex_alu_data, idex_rs, idex_rt, idex_sign_extend_inp, idex_instruction;
   logic [4:0]  idex_rs_address, idex_rt_address, idex_rd_address;
   logic        idex_regDest, idex_jump, idex_branch, idex_MemRead, idex_MemtoReg;
   logic        idex_MemWrite, idex_ALUSrc, idex_RegWrite;
   logic [1:0]  idex_ALUOp;
   logic [31:0] idex_alu_data_out, idex_rs_out, idex_rt_out, idex_sign_extend_inp_out;
   logic [31:0] idex_instruction_out;
   logic [4:0]  idex_rs_address_out, idex_rt_address_out, idex_rd_address_out;
   logic        idex_regDest_out, idex_jump_out, idex_branch_out, idex_MemRead_out;
   logic        idex_MemtoReg_out, idex_MemWrite_out, idex_ALUSrc_out, idex_RegWrite_out;
   logic [1:0]  idex_ALUOp_out;

   logic [31:0] exmem_alu_data1, exmem_alu_data2, exmem_rt;
   logic        exmem_zero;
   logic [4:0]  exmem_reg_des_address;
   logic        exmem_jump, exmem_branch, exmem_MemRead, exmem_MemtoReg, exmem_MemWrite;
   logic        exmem_RegWrite;
   logic [31:0] exmem_alu_data_out1, exmem_alu_data_out2, exmem_rt_out;
   logic        exmem_zero_out;
   logic [4:0]  exmem_reg_des_address_out;
   logic        exmem_jump_out, exmem_branch_out, exmem_MemRead_out, exmem_MemtoReg_out;
   logic        exmem_MemWrite_out, exmem_RegWrite_out;

   modport master (
      output ifid_enable, ifid_alu_data, ifid_inst_mem_data,
      input  ifid_alu_data_out, ifid_inst_mem_data_out,
      output idex_stall, idex_alu_data, idex_rs, idex_rt, idex_sign_extend_inp, idex_instruction,
      output idex_rs_address, idex_rt_address, idex_rd_address,
      output idex_regDest, idex_jump, idex_branch, idex_MemRead, idex_MemtoReg,
      output idex_MemWrite, idex_ALUSrc, idex_RegWrite, idex_ALUOp,
      input  idex_alu_data_out, idex_rs_out, idex_rt_out, idex_sign_extend_inp_out,
      input  idex_instruction_out, idex_rs_address_out, idex_rt_address_out, idex_rd_address_out,
      input  idex_regDest_out, idex_jump_out, idex_branch_out, idex_MemRead_out,
      input  idex_MemtoReg_out, idex_MemWrite_out, idex_ALUSrc_out, idex_RegWrite_out,
      input  idex_ALUOp_out,
      output exmem_alu_data1, exmem_alu_data2, exmem_rt, exmem_zero, exmem_reg_des_address,
      output exmem_jump, exmem_branch, exmem_MemRead, exmem_MemtoReg, exmem_MemWrite,
      output exmem_RegWrite,
      input  exmem_alu_data_out1, exmem_alu_data_out2, exmem_rt_out, exmem_zero_out,
      input  exmem_reg_des_address_out, exmem_jump_out, exmem_branch_out, exmem_MemRead_out,
      input  exmem_MemtoReg_out, exmem_MemWrite_out, exmem_RegWrite_out
   );

   modport slave (
      input  ifid_enable, ifid_alu_data, ifid_inst_mem_data,
      output ifid_alu_data_out, ifid_inst_mem_data_out,
      input  idex_stall, idex_alu_data, idex_rs, idex_rt, idex_sign_extend_inp, idex_instruction,
      input  idex_rs_address, idex_rt_address, idex_rd_address,
      input  idex_regDest, idex_jump, idex_branch, idex_MemRead, idex_MemtoReg,
      input  idex_MemWrite, idex_ALUSrc, idex_RegWrite, idex_ALUOp,
      output idex_alu_data_out, idex_rs_out, idex_rt_out, idex_sign_extend_inp_out,
      output idex_instruction_out, idex_rs_address_out, idex_rt_address_out, idex_rd_address_out,
      output idex_regDest_out, idex_jump_out, idex_branch_out, idex_MemRead_out,
      output idex_MemtoReg_out, idex_MemWrite_out, idex_ALUSrc_out, idex_RegWrite_out,
      output idex_ALUOp_out,
      input  exmem_alu_data1, exmem_alu_data2, exmem_rt, exmem_zero, exmem_reg_des_address,
      input  exmem_jump, exmem_branch, exmem_MemRead, exmem_MemtoReg, exmem_MemWrite,
      input  exmem_RegWrite,
      output exmem_alu_data_out1, exmem_alu_data_out2, exmem_rt_out, exmem_zero_out,
      output exmem_reg_des_address_out, exmem_jump_out, exmem_branch_out, exmem_MemRead_out,
      output exmem_MemtoReg_out, exmem_MemWrite_out, exmem_RegWrite_out
   );
endinterface

// File: rtl/if_id_ex_mem_pipeline_regs.sv
// IF/ID, ID/EX and EX/MEM pipeline registers: three independent one-cycle stages with
// an IF/ID load enable, an ID/EX control bubble, and a common synchronous reset.
module if_id_ex_mem_pipeline_regs (
   input logic                             clk,
   input logic                             reset,
   if_id_ex_mem_pipeline_regs_if.slave     pipe
);

   typedef struct packed {
      logic [31:0] alu_data;
      logic [31:0] inst_mem_data;
   } ifid_t;

   typedef struct packed {
      logic       reg_dest, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
      logic [1:0] alu_op;
   } idex_ctrl_t;

   typedef struct packed {
      logic [31:0] alu_data, rs, rt, sign_extend, instruction;
      logic [4:0]  rs_address, rt_address, rd_address;
   } idex_data_t;

   typedef struct packed {
      logic [31:0] alu_data1, alu_data2, rt;
      logic        zero;
      logic [4:0]  reg_des_address;
      logic        jump, branch, mem_read, mem_to_reg, mem_write, reg_write;
   } exmem_t;

   ifid_t      ifid_d, ifid_q;
   idex_ctrl_t idex_ctrl_d, idex_ctrl_q;
   idex_data_t idex_data_d, idex_data_q;
   exmem_t     exmem_d, exmem_q;

   always_comb begin
      ifid_d = ifid_q;
      if (pipe.ifid_enable) begin
         ifid_d = '{alu_data: pipe.ifid_alu_data, inst_mem_data: pipe.ifid_inst_mem_data};
      end

      // A stall only squashes the control word; the data still advances.
      idex_ctrl_d = '0;
      if (!pipe.idex_stall) begin
         idex_ctrl_d = '{reg_dest:   pipe.idex_regDest,  jump:      pipe.idex_jump,
                         branch:     pipe.idex_branch,   mem_read:  pipe.idex_MemRead,
                         mem_to_reg: pipe.idex_MemtoReg, mem_write: pipe.idex_MemWrite,
                         alu_src:    pipe.idex_ALUSrc,   reg_write: pipe.idex_RegWrite,
                         alu_op:     pipe.idex_ALUOp};
      end

      idex_data_d = '{alu_data:    pipe.idex_alu_data,    rs:          pipe.idex_rs,
                      rt:          pipe.idex_rt,          sign_extend: pipe.idex_sign_extend_inp,
                      instruction: pipe.idex_instruction, rs_address:  pipe.idex_rs_address,
                      rt_address:  pipe.idex_rt_address,  rd_address:  pipe.idex_rd_address};

      exmem_d = '{alu_data1: pipe.exmem_alu_data1, alu_data2: pipe.exmem_alu_data2,
                  rt: pipe.exmem_rt, zero: pipe.exmem_zero,
                  reg_des_address: pipe.exmem_reg_des_address,
                  jump: pipe.exmem_jump, branch: pipe.exmem_branch,
                  mem_read: pipe.exmem_MemRead, mem_to_reg: pipe.exmem_MemtoReg,
                  mem_write: pipe.exmem_MemWrite, reg_write: pipe.exmem_RegWrite};
   end

   // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_q      <= '0;
         idex_ctrl_q <= '0;
         idex_data_q <= '0;
         exmem_q     <= '0;
      end else begin
         ifid_q      <= ifid_d;
         idex_ctrl_q <= idex_ctrl_d;
         idex_data_q <= idex_data_d;
         exmem_q     <= exmem_d;
      end
   end

   assign pipe.ifid_alu_data_out      = ifid_q.alu_data;
   assign pipe.ifid_inst_mem_data_out = ifid_q.inst_mem_data;

   assign pipe.idex_alu_data_out        = idex_data_q.alu_data;
   assign pipe.idex_rs_out              = idex_data_q.rs;
   assign pipe.idex_rt_out              = idex_data_q.rt;
   assign pipe.idex_sign_extend_inp_out = idex_data_q.sign_extend;
   assign pipe.idex_instruction_out     = idex_data_q.instruction;
   assign pipe.idex_rs_address_out      = idex_data_q.rs_address;
   assign pipe.idex_rt_address_out      = idex_data_q.rt_address;
   assign pipe.idex_rd_address_out      = idex_data_q.rd_address;
   assign pipe.idex_regDest_out         = idex_ctrl_q.reg_dest;
   assign pipe.idex_jump_out            = idex_ctrl_q.jump;
   assign pipe.idex_branch_out          = idex_ctrl_q.branch;
   assign pipe.idex_MemRead_out         = idex_ctrl_q.mem_read;
   assign pipe.idex_MemtoReg_out        = idex_ctrl_q.mem_to_reg;
   assign pipe.idex_MemWrite_out        = idex_ctrl_q.mem_write;
   assign pipe.idex_ALUSrc_out          = idex_ctrl_q.alu_src;
   assign pipe.idex_RegWrite_out        = idex_ctrl_q.reg_write;
   assign pipe.idex_ALUOp_out           = idex_ctrl_q.alu_op;

   assign pipe.exmem_alu_data_out1       = exmem_q.alu_data1;
   assign pipe.exmem_alu_data_out2       = exmem_q.alu_data2;
   assign pipe.exmem_rt_out              = exmem_q.rt;
   assign pipe.exmem_zero_out            = exmem_q.zero;
   assign pipe.exmem_reg_des_address_out = exmem_q.reg_des_address;
   assign pipe.exmem_jump_out            = exmem_q.jump;
   assign pipe.exmem_branch_out          = exmem_q.branch;
   assign pipe.exmem_MemRead_out         = exmem_q.mem_read;
   assign pipe.exmem_MemtoReg_out        = exmem_q.mem_to_reg;
   assign pipe.exmem_MemWrite_out        = exmem_q.mem_write;
   assign pipe.exmem_RegWrite_out        = exmem_q.reg_write;

endmodule

// File: tb/tb_if_id_ex_mem_pipeline_regs.sv
// Directed bench for the pipeline registers: a one-edge-per-row vector table followed by
// hand-written mid-cycle input-change and mid-cycle reset sequences.
module tb_if_id_ex_mem_pipeline_regs;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   if_id_ex_mem_pipeline_regs_if bus ();

   if_id_ex_mem_pipeline_regs dut (.clk(clk), .reset(reset), .pipe(bus));

   // ctrl = {regDest, jump, branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp[1:0]}
   // aux feeds the remaining data/control inputs through distinct rotations (zero maps to zero).
   typedef struct {
      logic        rst, en, stall;
      logic [31:0] if_a, if_i, rs, rt;
      logic [4:0]  rt_adr;
      logic [9:0]  ctrl;
      logic [31:0] ex_a2;
      logic        ex_zero, ex_br;
      logic [4:0]  ex_rd;
      logic [31:0] aux;
      logic [31:0] e_if_a, e_if_i, e_rs, e_rt;
      logic [4:0]  e_rt_adr;
      logic [9:0]  e_ctrl;
      logic [31:0] e_ex_a2;
      logic        e_zero, e_br;
      logic [4:0]  e_rd;
      logic [31:0] e_aux;
   } vec_t;

   vec_t vecs [7];

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset                      = v.rst;
      bus.ifid_enable            = v.en;
      bus.ifid_alu_data          = v.if_a;
      bus.ifid_inst_mem_data     = v.if_i;
      bus.idex_stall             = v.stall;
      bus.idex_rs                = v.rs;
      bus.idex_rt                = v.rt;
      bus.idex_rt_address        = v.rt_adr;
      {bus.idex_regDest, bus.idex_jump, bus.idex_branch, bus.idex_MemRead, bus.idex_MemtoReg,
       bus.idex_MemWrite, bus.idex_ALUSrc, bus.idex_RegWrite, bus.idex_ALUOp} = v.ctrl;
      bus.idex_alu_data          = v.aux;
      bus.idex_sign_extend_inp   = rotl(v.aux, 16);
      bus.idex_instruction       = rotl(v.aux, 8);
      bus.idex_rs_address        = v.aux[4:0];
      bus.idex_rd_address        = v.aux[9:5];
      bus.exmem_alu_data1        = rotl(v.aux, 24);
      bus.exmem_alu_data2        = v.ex_a2;
      bus.exmem_rt               = rotl(v.aux, 4);
      bus.exmem_zero             = v.ex_zero;
      bus.exmem_branch           = v.ex_br;
      bus.exmem_reg_des_address  = v.ex_rd;
      {bus.exmem_RegWrite, bus.exmem_MemWrite, bus.exmem_MemtoReg, bus.exmem_MemRead,
       bus.exmem_jump} = v.aux[14:10];
   endtask

   task automatic check_vec(input vec_t v, input int k);
      string p;
      p = $sformatf("v%0d.", k);
      check({p, "ifid_alu"},  bus.ifid_alu_data_out, v.e_if_a);
      check({p, "ifid_inst"}, bus.ifid_inst_mem_data_out, v.e_if_i);
      check({p, "idex_rs"},   bus.idex_rs_out, v.e_rs);
      check({p, "idex_rt"},   bus.idex_rt_out, v.e_rt);
      check({p, "idex_rt_adr"}, 32'(bus.idex_rt_address_out), 32'(v.e_rt_adr));
      check({p, "idex_ctrl"}, 32'({bus.idex_regDest_out, bus.idex_jump_out, bus.idex_branch_out,
            bus.idex_MemRead_out, bus.idex_MemtoReg_out, bus.idex_MemWrite_out,
            bus.idex_ALUSrc_out, bus.idex_RegWrite_out, bus.idex_ALUOp_out}), 32'(v.e_ctrl));
      check({p, "idex_alu"},  bus.idex_alu_data_out, v.e_aux);
      check({p, "idex_sext"}, bus.idex_sign_extend_inp_out, rotl(v.e_aux, 16));
      check({p, "idex_inst"}, bus.idex_instruction_out, rotl(v.e_aux, 8));
      check({p, "idex_rs_adr"}, 32'(bus.idex_rs_address_out), 32'(v.e_aux[4:0]));
      check({p, "idex_rd_adr"}, 32'(bus.idex_rd_address_out), 32'(v.e_aux[9:5]));
      check({p, "exmem_alu1"}, bus.exmem_alu_data_out1, rotl(v.e_aux, 24));
      check({p, "exmem_alu2"}, bus.exmem_alu_data_out2, v.e_ex_a2);
      check({p, "exmem_rt"},   bus.exmem_rt_out, rotl(v.e_aux, 4));
      check({p, "exmem_zero"}, 32'(bus.exmem_zero_out), 32'(v.e_zero));
      check({p, "exmem_br"},   32'(bus.exmem_branch_out), 32'(v.e_br));
      check({p, "exmem_rd"},   32'(bus.exmem_reg_des_address_out), 32'(v.e_rd));
      check({p, "exmem_ctrl"}, 32'({bus.exmem_RegWrite_out, bus.exmem_MemWrite_out,
            bus.exmem_MemtoReg_out, bus.exmem_MemRead_out, bus.exmem_jump_out}),
            32'(v.e_aux[14:10]));
   endtask

   initial begin
      // rst en st  if_a          if_i          rs            rt            adr    ctrl      ex_a2         z     br    rd      aux
      //            e_if_a        e_if_i        e_rs          e_rt          e_adr  e_ctrl    e_ex_a2       e_z   e_br  e_rd    e_aux
      vecs[0] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  5'd31, 10'h3FF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF,
                  32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 10'h000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h8C22_0004, 32'h11, 32'h22,
                  5'd2, 10'h046, 32'h0000_000A, 1'b1, 1'b1, 5'd3, 32'h1234_5678,
                  32'h0000_0005, 32'h8C22_0004, 32'h11, 32'h22, 5'd2, 10'h046,
                  32'h0000_000A, 1'b1, 1'b1, 5'd3, 32'h1234_5678};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0006, 32'h0, 32'h11, 32'h22,
                  5'd2, 10'h046, 32'h0000_000B, 1'b0, 1'b0, 5'd4, 32'hCAFE_F00D,
                  32'h0000_0005, 32'h8C22_0004, 32'h11, 32'h22, 5'd2, 10'h000,
                  32'h0000_000B, 1'b0, 1'b0, 5'd4, 32'hCAFE_F00D};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0006, 32'h0, 32'hDEAD_BEEF, 32'h0,
                  5'd31, 10'h3FF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF,
                  32'h0000_0006, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd31, 10'h3FF,
                  32'hFFFF_FFFF, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                  5'd9, 10'h3FF, 32'h5555_5555, 1'b1, 1'b1, 5'd12, 32'h6666_6666,
                  32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 10'h000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 32'hA000_0001, 32'h2002_0003, 32'h0000_0F0F, 32'h0000_F0F0,
                  5'd7, 10'h155, 32'h0000_0001, 1'b0, 1'b1, 5'd9, 32'h8000_0001,
                  32'hA000_0001, 32'h2002_0003, 32'h0000_0F0F, 32'h0000_F0F0, 5'd7, 10'h155,
                  32'h0000_0001, 1'b0, 1'b1, 5'd9, 32'h8000_0001};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0000_0007, 32'h0000_0007, 32'h33, 32'h44,
                  5'd5, 10'h2AA, 32'h0000_0042, 1'b1, 1'b0, 5'd17, 32'h0F00_00F0,
                  32'hA000_0001, 32'h2002_0003, 32'h33, 32'h44, 5'd5, 10'h000,
                  32'h0000_0042, 1'b1, 1'b0, 5'd17, 32'h0F00_00F0};

      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         drive(vecs[k]);
         @(posedge clk);
         #1;
         check_vec(vecs[k], k);
      end

      // Input changes between edges must not reach the outputs before the next edge.
      @(negedge clk);
      bus.exmem_alu_data2   = 32'h0000_00A0;
      bus.ifid_enable       = 1'b1;
      bus.ifid_alu_data     = 32'h0000_0099;
      bus.idex_stall        = 1'b0;
      #2;
      check("mid.exmem_alu2", bus.exmem_alu_data_out2, 32'h0000_0042);
      check("mid.ifid_alu",   bus.ifid_alu_data_out, 32'hA000_0001);
      check("mid.idex_ctrl",  32'({bus.idex_regDest_out, bus.idex_ALUOp_out}), 32'h0);
      @(posedge clk);
      #1;
      check("edge.exmem_alu2", bus.exmem_alu_data_out2, 32'h0000_00A0);
      check("edge.ifid_alu",   bus.ifid_alu_data_out, 32'h0000_0099);
      check("edge.idex_ctrl",  32'({bus.idex_regDest_out, bus.idex_ALUOp_out}), 32'h6);

      // Reset raised mid-cycle takes effect only at the following edge.
      @(negedge clk);
      reset = 1'b1;
      #2;
      check("rmid.ifid_alu",   bus.ifid_alu_data_out, 32'h0000_0099);
      check("rmid.exmem_alu2", bus.exmem_alu_data_out2, 32'h0000_00A0);
      @(posedge clk);
      #1;
      check("redge.ifid_alu",   bus.ifid_alu_data_out, 32'h0);
      check("redge.exmem_alu2", bus.exmem_alu_data_out2, 32'h0);
      check("redge.idex_rs",    bus.idex_rs_out, 32'h0);

      // First edge after reset loads normally.
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post.ifid_alu",   bus.ifid_alu_data_out, 32'h0000_0099);
      check("post.exmem_alu2", bus.exmem_alu_data_out2, 32'h0000_00A0);
      check("post.idex_rs",    bus.idex_rs_out, 32'h33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_ex_mem_pipeline_regs.md
IF_ID_EX_MEM_PIPELINE_REGS -- requirements
Module: if_id_ex_mem_pipeline_regs

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ifid_enable  input  1  IF/ID load enable; 0 holds the stage.
REQ-005 ifid_alu_data, ifid_inst_mem_data  input  32 each  PC+1 and fetched instruction.
REQ-006 ifid_alu_data_out, ifid_inst_mem_data_out  output  32 each  registered IF/ID contents.
REQ-007 idex_stall  input  1  inserts a bubble into ID/EX.
REQ-008 idex_alu_data, idex_rs, idex_rt, idex_sign_extend_inp, idex_instruction  input  32 each  ID-stage data.
REQ-009 idex_rs_address, idex_rt_address, idex_rd_address  input  5 each  register specifiers.
REQ-010 idex_regDest, idex_jump, idex_branch, idex_MemRead, idex_MemtoReg, idex_MemWrite, idex_ALUSrc, idex_RegWrite  input  1 each; idex_ALUOp  input  2  control signals.
REQ-011 Each REQ-008..010 input SHALL have a same-named output with suffix _out and the same width.
REQ-012 exmem_alu_data1 (branch target), exmem_alu_data2 (ALU result), exmem_rt  input  32 each; exmem_zero  input  1; exmem_reg_des_address  input  5.
REQ-013 exmem_jump, exmem_branch, exmem_MemRead, exmem_MemtoReg, exmem_MemWrite, exmem_RegWrite  input  1 each.
REQ-014 Each REQ-012..013 input SHALL have a same-named output with suffix _out (exmem_alu_data_out1/out2 for alu_data1/2).

Function
REQ-015 Every output SHALL come directly from a flip-flop; no combinational input-to-output path.
REQ-016 Latency input-to-output SHALL be exactly one clk cycle per stage; the three stages are independent (no internal chaining).
REQ-017 IF/ID: reset=0, ifid_enable=1 -> both outputs load inputs at the edge; ifid_enable=0 -> both hold the previous value.
REQ-018 ID/EX: reset=0, idex_stall=0 -> all ID/EX outputs load their inputs.
REQ-019 ID/EX: reset=0, idex_stall=1 -> all nine control outputs (eight 1-bit plus ALUOp) load 0 (bubble); data, address and instruction outputs still load their inputs.
REQ-020 EX/MEM: reset=0 -> all outputs load their inputs every edge; no enable or stall.
REQ-021 Widths SHALL be passed unchanged; no extension, truncation or arithmetic.
REQ-022 Simultaneous ifid_enable=0 and idex_stall=1 SHALL be legal: IF/ID holds while ID/EX takes a bubble in the same edge.
REQ-023 Input changes between edges SHALL have no effect on outputs.

Reset
REQ-024 reset=1 at a rising edge SHALL clear every output of all three stages to 0, overriding ifid_enable and idex_stall.
REQ-025 Reset SHALL be synchronous only; asserting reset between edges SHALL not change outputs until the next edge.
REQ-026 The first edge with reset=0 SHALL load normally per REQ-017..020.

Verification
REQ-027 reset=1 one edge with all inputs 0xFFFFFFFF/1 -> all outputs 0.
REQ-028 ifid_alu_data=0x00000005, ifid_inst_mem_data=0x8C220004, enable=1, one edge -> outputs 0x00000005/0x8C220004; then enable=0, inputs 0x6/0x0 -> outputs unchanged.
REQ-029 idex inputs rs=0x11, rt=0x22, rt_address=2, MemRead=1, RegWrite=1, ALUOp=2'b10, stall=0 -> same values at outputs after one edge; repeat with stall=1 -> all controls 0, rs_out=0x11, rt_address_out=2.
REQ-030 exmem_alu_data2=0x0000000A, exmem_zero=1, exmem_branch=1, exmem_reg_des_address=5'd3 -> exmem outputs 0xA, 1, 1, 3 after one edge; inputs changed mid-cycle -> no change until next edge.
REQ-031 With outputs nonzero, assert reset together with ifid_enable=1 and idex_stall=0 -> all outputs 0 at that edge; deassert -> next edge loads inputs.
REQ-032 ifid_enable=0 and idex_stall=1 same edge -> IF/ID holds prior values, ID/EX controls 0, EX/MEM loads normally.
